// File: rtl/debug_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debug_cmd_parser                                           |
// | Description : Decodes framed register-write commands from the debug UART |
// |               receive byte stream. Frame = SYNC, ADDR, DATA, CSUM where  |
// |               CSUM = (ADDR + DATA) mod 256. A good frame produces a      |
// |               one-cycle write strobe with addr/data; a bad checksum or a |
// |               stalled frame produces a one-cycle error pulse.            |
// | Ports       : i_clk     system clock                                     |
// |               i_rst_n   asynchronous active-low reset                    |
// |               i_byte    received byte, valid while i_ready=1             |
// |               i_ready   one-cycle strobe: new byte on i_byte             |
// |               o_wr_en   one-cycle pulse: valid frame decoded             |
// |               o_addr    address of last valid frame (held)               |
// |               o_data    data of last valid frame (held)                  |
// |               o_err     one-cycle pulse: checksum error or timeout       |
// |               o_frames  count of valid frames, wraps 255->0              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module debug_cmd_parser #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 250000,
   parameter int         TIMEOUT_WIDTH  = 18
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_byte,
   input  logic       i_ready,
   output logic       o_wr_en,
   output logic [7:0] o_addr,
   output logic [7:0] o_data,
   output logic       o_err,
   output logic [7:0] o_frames
);

   typedef enum logic [1:0] {
      S_SYNC = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_CSUM = 2'd3
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] C_TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                   state_q;
   logic [7:0]               addr_sh_q;
   logic [7:0]               data_sh_q;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_d;
   logic                     timeout_w;
   logic [7:0]               csum_w;

   // Checksum wraps naturally in 8 bits.
   assign csum_w = addr_sh_q + data_sh_q;

   // Inter-byte timeout. A byte arriving on the terminal count wins over the
   // timeout, so i_ready is checked before the terminal count.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      timeout_w = 1'b0;
      if (state_q == S_SYNC) begin
         tmo_cnt_d = '0;
      end else if (i_ready) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q == C_TMO_LAST) begin
         tmo_cnt_d = '0;
         timeout_w = 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_SYNC;
         addr_sh_q <= 8'h00;
         data_sh_q <= 8'h00;
         tmo_cnt_q <= '0;
         o_wr_en   <= 1'b0;
         o_addr    <= 8'h00;
         o_data    <= 8'h00;
         o_err     <= 1'b0;
         o_frames  <= 8'h00;
      end else begin
         o_wr_en   <= 1'b0;
         o_err     <= 1'b0;
         tmo_cnt_q <= tmo_cnt_d;
         if (i_ready) begin
            case (state_q)
               S_SYNC: begin
                  // Non-sync bytes between frames are line noise; drop quietly.
                  if (i_byte == SYNC_BYTE) begin
                     state_q <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  addr_sh_q <= i_byte;
                  state_q   <= S_DATA;
               end
               S_DATA: begin
                  data_sh_q <= i_byte;
                  state_q   <= S_CSUM;
               end
               S_CSUM: begin
                  state_q <= S_SYNC;
                  if (i_byte == csum_w) begin
                     o_wr_en  <= 1'b1;
                     o_addr   <= addr_sh_q;
                     o_data   <= data_sh_q;
                     o_frames <= o_frames + 8'd1;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
               default: begin
                  state_q <= S_SYNC;
               end
            endcase
         end else if (timeout_w) begin
            state_q <= S_SYNC;
            o_err   <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_debug_cmd_parser                                        |
// | Description : Scoreboard bench for debug_cmd_parser. Expected write/err  |
// |               events are queued as frames are driven and compared when  |
// |               the DUT pulses o_wr_en or o_err.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_debug_cmd_parser;

   localparam int C_TMO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] r_byte;
   logic       r_ready;
   logic       w_wr_en;
   logic [7:0] w_addr;
   logic [7:0] w_data;
   logic       w_err;
   logic [7:0] w_frames;

   debug_cmd_parser #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (C_TMO),
      .TIMEOUT_WIDTH  (5)
   ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_byte   (r_byte),
      .i_ready  (r_ready),
      .o_wr_en  (w_wr_en),
      .o_addr   (w_addr),
      .o_data   (w_data),
      .o_err    (w_err),
      .o_frames (w_frames)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] frames;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         wr_seen  = 0;
   logic [7:0] m_addr   = 8'h00;
   logic [7:0] m_data   = 8'h00;
   logic [7:0] m_frames = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Output monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (w_wr_en === 1'b1 || w_err === 1'b1)) begin
         if (w_wr_en === 1'b1) wr_seen++;
         if (sb_q.size() == 0) begin
            check_eq("unexpected_pulse", {30'd0, w_wr_en, w_err}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("pulse_kind", {30'd0, w_wr_en, w_err}, e.is_wr ? 32'd2 : 32'd1);
            check_eq("o_addr",   {24'd0, w_addr},   {24'd0, e.addr});
            check_eq("o_data",   {24'd0, w_data},   {24'd0, e.data});
            check_eq("o_frames", {24'd0, w_frames}, {24'd0, e.frames});
         end
      end
   end

   task automatic strobe(input logic [7:0] b);
      @(negedge clk);
      r_byte  = b;
      r_ready = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      r_ready = 1'b0;
   endtask

   task automatic drive(input logic [7:0] b);
      strobe(b);
      idle();
   endtask

   // Queue the outcome a CSUM byte should produce, before it is driven.
   task automatic expect_csum(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      exp_t e;
      if (c == 8'(a + d)) begin
         m_addr   = a;
         m_data   = d;
         m_frames = m_frames + 8'd1;
         e.is_wr  = 1'b1;
      end else begin
         e.is_wr  = 1'b0;
      end
      e.addr   = m_addr;
      e.data   = m_data;
      e.frames = m_frames;
      sb_q.push_back(e);
   endtask

   task automatic expect_timeout();
      exp_t e;
      e.is_wr  = 1'b0;
      e.addr   = m_addr;
      e.data   = m_data;
      e.frames = m_frames;
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      drive(8'hA5);
      drive(a);
      drive(d);
      expect_csum(a, d, c);
      drive(c);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq(tag, {w_wr_en, w_err, w_addr, w_data, w_frames}, 26'd0);
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] d;
      rst_n   = 1'b0;
      r_byte  = 8'h00;
      r_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset_state");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1. Good frame.
      send_frame(8'h10, 8'h22, 8'h32);
      repeat (3) @(negedge clk);

      // 2. Bad checksum; outputs hold.
      send_frame(8'h10, 8'h22, 8'h33);
      repeat (3) @(negedge clk);

      // 3. Garbage, then sync byte used as payload.
      drive(8'h00);
      drive(8'hFF);
      drive(8'h5A);
      send_frame(8'hA5, 8'hA5, 8'h4A);
      repeat (3) @(negedge clk);

      // 4a. Stall after ADDR: error pulse exactly C_TMO idle cycles after.
      drive(8'hA5);
      expect_timeout();
      drive(8'h01);
      repeat (C_TMO - 1) @(negedge clk);
      check_eq("tmo_not_early", {31'd0, w_err}, 32'd0);
      @(negedge clk);
      check_eq("tmo_pulse", {31'd0, w_err}, 32'd1);
      @(negedge clk);
      check_eq("tmo_one_cycle", {31'd0, w_err}, 32'd0);
      send_frame(8'h01, 8'h02, 8'h03);
      repeat (3) @(negedge clk);

      // 4b. Byte lands exactly on the timeout cycle: byte wins.
      drive(8'hA5);
      drive(8'h01);
      repeat (C_TMO - 2) @(negedge clk);
      drive(8'h02);
      expect_csum(8'h01, 8'h02, 8'h03);
      drive(8'h03);
      repeat (3) @(negedge clk);
      check_eq("sb_drained_4", sb_q.size(), 32'd0);

      // 5. 256 frames with consecutive strobes; counter wraps from 0 to 0.
      @(negedge clk);
      rst_n = 1'b0;
      m_addr = 8'h00; m_data = 8'h00; m_frames = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 256; i++) begin
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         strobe(8'hA5);
         strobe(a);
         strobe(d);
         expect_csum(a, d, 8'(a + d));
         strobe(8'(a + d));
      end
      idle();
      repeat (3) @(negedge clk);
      check_eq("wr_count_256", wr_seen, 32'd256);
      check_eq("frames_wrap", {24'd0, w_frames}, 32'd0);

      // 6. Async reset mid-frame.
      send_frame(8'h33, 8'h44, 8'h77);
      repeat (3) @(negedge clk);
      drive(8'hA5);
      drive(8'h01);
      #2;
      rst_n = 1'b0;
      m_addr = 8'h00; m_data = 8'h00; m_frames = 8'h00;
      #1;
      check_zero_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h02);
      drive(8'h03);
      repeat (3) @(negedge clk);
      check_eq("post_reset_ignored", {30'd0, w_wr_en, w_err}, 32'd0);
      send_frame(8'h07, 8'h08, 8'h0F);
      repeat (4) @(negedge clk);
      check_eq("final_frames", {24'd0, w_frames}, 32'd1);
      check_eq("sb_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
